// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants for the transmit path: packet types, header
// field values, preamble/SFD and CRC-32 parameters, plus the ARP reply byte map.
package eth_pkg;

  typedef enum logic [1:0] {
    PKT_NONE     = 2'b00,
    PKT_ARP_REQ  = 2'b01,
    PKT_ARP_RESP = 2'b10,
    PKT_UDP      = 2'b11
  } pkt_type_e;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_RESP  = 16'h0002;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam int          PREAMBLE_LEN   = 8;
  localparam int          ETH_MIN_BODY   = 60;
  localparam int          FCS_LEN        = 4;

  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

  // Byte idx (0..59) of a minimum-size ARP reply frame, without preamble/FCS.
  function automatic logic [7:0] arp_reply_byte(input logic [6:0]  idx,
                                                input logic [47:0] dst_mac,
                                                input logic [31:0] dst_ip,
                                                input logic [47:0] src_mac,
                                                input logic [31:0] src_ip);
    logic [7:0] b;
    int i;
    i = {25'd0, idx};
    b = 8'h00;
    if (i < 6)        b = 8'(dst_mac >> (8 * (5 - i)));
    else if (i < 12)  b = 8'(src_mac >> (8 * (11 - i)));
    else if (i < 14)  b = 8'(ETHERTYPE_ARP >> (8 * (13 - i)));
    else if (i < 16)  b = 8'(ARP_HTYPE_ETH >> (8 * (15 - i)));
    else if (i < 18)  b = 8'(ETHERTYPE_IPV4 >> (8 * (17 - i)));
    else if (i == 18) b = ARP_HLEN;
    else if (i == 19) b = ARP_PLEN;
    else if (i < 22)  b = 8'(ARP_OPER_RESP >> (8 * (21 - i)));
    else if (i < 28)  b = 8'(src_mac >> (8 * (27 - i)));
    else if (i < 32)  b = 8'(src_ip >> (8 * (31 - i)));
    else if (i < 38)  b = 8'(dst_mac >> (8 * (37 - i)));
    else if (i < 42)  b = 8'(dst_ip >> (8 * (41 - i)));
    return b;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB first).
// Holds no state, so any transmit stage can wrap its own CRC register around it.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (CRC32_POLY & {32{c[0] ^ data[i]}});
    end
    crc_out = c;
  end

endmodule

// File: rtl/arp_reply_tx.sv
// Builds and streams a complete ARP reply frame (preamble, body, FCS, IFG).
// Define ARP_REPLY_TX_FILTER_EN to answer only requests whose TPA is our IP.
//
// state      | meaning
// S_IDLE     | waiting for an ARP request, no valid output
// S_PREAMBLE | 7x 0x55 then SFD 0xD5
// S_BODY     | 60-byte Ethernet header + ARP payload + padding, CRC accumulates
// S_FCS      | ~crc, least significant byte first
// S_IFG      | IFG_BYTES idle cycles, still busy
module arp_reply_tx
  import eth_pkg::*;
#(
  parameter int IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [1:0]  i_pkt_type,
  input  logic [47:0] i_SHA,
  input  logic [31:0] i_SPA,
  input  logic [31:0] i_TPA,
  input  logic        i_tx_rdy,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int IFG_W = $clog2(IFG_BYTES + 1);
  localparam logic [6:0] PRE_LAST  = 7'(PREAMBLE_LEN - 1);
  localparam logic [6:0] BODY_LAST = 7'(ETH_MIN_BODY - 1);
  localparam logic [6:0] FCS_LAST  = 7'(FCS_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_BODY, S_FCS, S_IFG
  } state_e;

  state_e       state, state_nx;
  logic [6:0]   cnt, cnt_nx, cnt_inc;
  logic [31:0]  crc, crc_nx, crc_upd, fcs_word;
  logic [47:0]  req_mac;
  logic [31:0]  req_ip;
  logic [IFG_W-1:0] ifg_cnt, ifg_nx;
  logic [7:0]   data_nx;
  logic         vl_nx, drop_nx, latch_req;
  logic         req_pass, req_ok, accept;

`ifdef ARP_REPLY_TX_FILTER_EN
  assign req_pass = (i_TPA == i_self_ip);
`else
  logic unused_tpa;
  assign unused_tpa = ^i_TPA;
  assign req_pass   = 1'b1;
`endif

  assign req_ok   = (i_pkt_type == PKT_ARP_REQ) && req_pass;
  assign accept   = o_data_vl && i_tx_rdy;
  assign cnt_inc  = cnt + 7'd1;
  assign fcs_word = ~crc;
  assign o_busy   = (state != S_IDLE);

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (o_data),
    .crc_out (crc_upd)
  );

  // Output is registered, so each branch loads the byte for the position
  // that becomes current after this edge.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    crc_nx    = crc;
    ifg_nx    = ifg_cnt;
    data_nx   = o_data;
    vl_nx     = o_data_vl;
    latch_req = 1'b0;
    drop_nx   = req_ok && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        data_nx = 8'h00;
        vl_nx   = 1'b0;
        if (req_ok) begin
          state_nx  = S_PREAMBLE;
          cnt_nx    = 7'd0;
          crc_nx    = CRC32_INIT;
          data_nx   = PREAMBLE_BYTE;
          vl_nx     = 1'b1;
          latch_req = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (accept) begin
          if (cnt == PRE_LAST) begin
            state_nx = S_BODY;
            cnt_nx   = 7'd0;
            data_nx  = arp_reply_byte(7'd0, req_mac, req_ip, i_self_mac, i_self_ip);
          end else begin
            cnt_nx  = cnt_inc;
            data_nx = (cnt_inc == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
          end
        end
      end
      S_BODY: begin
        if (accept) begin
          crc_nx = crc_upd;
          if (cnt == BODY_LAST) begin
            state_nx = S_FCS;
            cnt_nx   = 7'd0;
            data_nx  = ~crc_upd[7:0];
          end else begin
            cnt_nx  = cnt_inc;
            data_nx = arp_reply_byte(cnt_inc, req_mac, req_ip, i_self_mac, i_self_ip);
          end
        end
      end
      S_FCS: begin
        if (accept) begin
          if (cnt == FCS_LAST) begin
            state_nx = S_IFG;
            cnt_nx   = 7'd0;
            ifg_nx   = IFG_W'(IFG_BYTES - 1);
            data_nx  = 8'h00;
            vl_nx    = 1'b0;
          end else begin
            cnt_nx  = cnt_inc;
            data_nx = 8'(fcs_word >> {cnt_inc[1:0], 3'b000});
          end
        end
      end
      S_IFG: begin
        data_nx = 8'h00;
        vl_nx   = 1'b0;
        if (ifg_cnt == '0) begin
          state_nx = S_IDLE;
          cnt_nx   = 7'd0;
        end else begin
          ifg_nx = ifg_cnt - 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 7'd0;
        data_nx  = 8'h00;
        vl_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 7'd0;
      crc       <= CRC32_INIT;
      ifg_cnt   <= '0;
      req_mac   <= 48'd0;
      req_ip    <= 32'd0;
      o_data    <= 8'h00;
      o_data_vl <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      crc       <= crc_nx;
      ifg_cnt   <= ifg_nx;
      o_data    <= data_nx;
      o_data_vl <= vl_nx;
      o_drop    <= drop_nx;
      if (latch_req) begin
        req_mac <= i_SHA;
        req_ip  <= i_SPA;
      end
    end
  end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx: table of requests plus drop and reset sequences.
module tb_arp_reply_tx;

  localparam logic [47:0] SELF_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] SELF_IP  = 32'hC0_A8_01_0A;
  localparam int          IFG      = 12;
`ifdef ARP_REPLY_TX_FILTER_EN
  localparam bit OTHER_TPA_REPLY = 1'b0;
`else
  localparam bit OTHER_TPA_REPLY = 1'b1;
`endif

  logic        clk, rst_n;
  logic [47:0] i_self_mac;
  logic [31:0] i_self_ip;
  logic [1:0]  i_pkt_type;
  logic [47:0] i_SHA;
  logic [31:0] i_SPA, i_TPA;
  logic        i_tx_rdy;
  logic [7:0]  o_data;
  logic        o_data_vl, o_busy, o_drop;

  arp_reply_tx #(.IFG_BYTES(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
    .i_pkt_type(i_pkt_type), .i_SHA(i_SHA), .i_SPA(i_SPA), .i_TPA(i_TPA),
    .i_tx_rdy(i_tx_rdy), .o_data(o_data), .o_data_vl(o_data_vl),
    .o_busy(o_busy), .o_drop(o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    bit          reply;
    int          mode;   // 0: rdy held high, 1: random rdy
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];
  logic [7:0] exp_frame [72];
  int  busy_cnt, drop_cnt;
  bit  fell, first_vl;
  logic [7:0] first_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_expected(input logic [47:0] sha, input logic [31:0] spa);
    logic [479:0] blob;
    logic [31:0]  c;
    blob = {sha, SELF_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
            SELF_MAC, SELF_IP, sha, spa, 144'h0};
    for (int i = 0; i < 7; i++) exp_frame[i] = 8'h55;
    exp_frame[7] = 8'hD5;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      exp_frame[8+i] = blob[479-8*i -: 8];
      c = crc_step(c, blob[479-8*i -: 8]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_frame[68+i] = c[8*i +: 8];
  endtask

  task automatic check_frame(input string tag, input logic [47:0] sha, input logic [31:0] spa);
    build_expected(sha, spa);
    chk({tag, " byte count"}, 64'(got.size()), 64'd72);
    for (int i = 0; i < 72; i++)
      if (i < got.size()) chk($sformatf("%s byte %0d", tag, i), 64'(got[i]), 64'(exp_frame[i]));
  endtask

  task automatic issue(input logic [1:0] t, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa);
    @(negedge clk);
    i_pkt_type = t;
    i_SHA = sha;
    i_SPA = spa;
    i_TPA = tpa;
  endtask

  // Observe one frame; inject_at >= 0 repeats the request that many cycles in.
  task automatic collect(input int mode, input int max_cyc, input int inject_at);
    bit seen;
    got.delete();
    busy_cnt = 0; drop_cnt = 0; fell = 0; seen = 0;
    first_vl = 0; first_data = 8'h00;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      i_pkt_type = (k == inject_at) ? 2'b01 : 2'b00;
      if (k == 0) begin
        first_vl = o_data_vl;
        first_data = o_data;
      end
      if (o_drop) drop_cnt++;
      if (o_busy) begin
        busy_cnt++;
        seen = 1;
      end else if (seen) begin
        fell = 1;
        break;
      end
      i_tx_rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (o_data_vl && i_tx_rdy) got.push_back(o_data);
    end
    i_tx_rdy = 1'b1;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b01, 48'h001122334455, 32'hC0A80114, SELF_IP,      1'b1, 0};
    vecs[1] = '{2'b01, 48'h001122334455, 32'hC0A80114, SELF_IP,      1'b1, 1};
    vecs[2] = '{2'b10, 48'h001122334455, 32'hC0A80114, SELF_IP,      1'b0, 0};
    vecs[3] = '{2'b11, 48'h001122334455, 32'hC0A80114, SELF_IP,      1'b0, 0};
    vecs[4] = '{2'b00, 48'h001122334455, 32'hC0A80114, SELF_IP,      1'b0, 0};
    vecs[5] = '{2'b01, 48'h001122334455, 32'hC0A80114, 32'hC0A80163, OTHER_TPA_REPLY, 0};
    vecs[6] = '{2'b01, 48'hA0B1C2D3E4F5, 32'h0A000007, SELF_IP,      1'b1, 0};

    rst_n = 1'b0;
    i_self_mac = SELF_MAC; i_self_ip = SELF_IP;
    i_pkt_type = 2'b00; i_SHA = '0; i_SPA = '0; i_TPA = '0; i_tx_rdy = 1'b1;
    #1;
    chk("reset o_data", 64'(o_data), 64'd0);
    chk("reset o_data_vl", 64'(o_data_vl), 64'd0);
    chk("reset o_busy", 64'(o_busy), 64'd0);
    chk("reset o_drop", 64'(o_drop), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].t, vecs[v].sha, vecs[v].spa, vecs[v].tpa);
      collect(vecs[v].mode, vecs[v].reply ? 600 : 100, -1);
      chk($sformatf("vec%0d drop count", v), 64'(drop_cnt), 64'd0);
      if (vecs[v].reply) begin
        chk($sformatf("vec%0d frame completes", v), 64'(fell), 64'd1);
        check_frame($sformatf("vec%0d", v), vecs[v].sha, vecs[v].spa);
        if (vecs[v].mode == 0) begin
          chk($sformatf("vec%0d first valid", v), 64'(first_vl), 64'd1);
          chk($sformatf("vec%0d first byte", v), 64'(first_data), 64'h55);
          chk($sformatf("vec%0d busy cycles", v), 64'(busy_cnt), 64'(72 + IFG));
        end
      end else begin
        chk($sformatf("vec%0d bytes emitted", v), 64'(got.size()), 64'd0);
        chk($sformatf("vec%0d busy cycles", v), 64'(busy_cnt), 64'd0);
      end
      repeat (3) @(negedge clk);
    end

    // Second request 5 cycles into the frame is dropped once.
    issue(2'b01, 48'h001122334455, 32'hC0A80114, SELF_IP);
    collect(0, 600, 5);
    chk("busy drop count", 64'(drop_cnt), 64'd1);
    chk("busy frame completes", 64'(fell), 64'd1);
    chk("busy busy cycles", 64'(busy_cnt), 64'(72 + IFG));
    check_frame("busy", 48'h001122334455, 32'hC0A80114);
    repeat (5) @(negedge clk);
    chk("busy no second frame", 64'(o_busy), 64'd0);

    // Reset while body byte 30 is presented; no resume, then a clean frame.
    begin
      int n, k;
      issue(2'b01, 48'h001122334455, 32'hC0A80114, SELF_IP);
      build_expected(48'h001122334455, 32'hC0A80114);
      n = 0; k = 0;
      while (n < 39 && k < 200) begin
        @(negedge clk);
        i_pkt_type = 2'b00;
        i_tx_rdy = 1'b1;
        if (o_data_vl) n++;
        k++;
      end
      chk("abort reached byte 30", 64'(n), 64'd39);
      chk("abort presented byte", 64'(o_data), 64'(exp_frame[38]));
      rst_n = 1'b0;
      #1;
      chk("abort o_busy", 64'(o_busy), 64'd0);
      chk("abort o_data_vl", 64'(o_data_vl), 64'd0);
      chk("abort o_data", 64'(o_data), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      collect(0, 20, -1);
      chk("post-reset idle bytes", 64'(got.size()), 64'd0);
      chk("post-reset idle busy", 64'(busy_cnt), 64'd0);
      issue(2'b01, 48'h665544332211, 32'hC0A80133, SELF_IP);
      collect(0, 600, -1);
      chk("post-reset frame completes", 64'(fell), 64'd1);
      check_frame("post-reset", 48'h665544332211, 32'hC0A80133);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
